// File: rtl/fg_fetch_responder.sv
// ============================================================================
// fg_fetch_responder
// ----------------------------------------------------------------------------
// Purpose:
//   Answers one foreground-pixel request per background pixel slot with a
//   fixed response delay of SRAM_READ_LATENCY+2 cycles after the request is
//   presented. In-frame active requests read the foreground SRAM. All other
//   requests are answered as "skip" without touching the SRAM. A single-entry
//   write holding register lets a frame writer update the SRAM. It uses any
//   cycle in which no read is being issued.
//
// Optional feature (compile-time):
//   FG_RESPONDER_TEST_PATTERN_EN - adds input ctrl_test_pattern. When it is
//   sampled high with a read request, the response carries a coordinate
//   pattern {x[4:0], y[5:0], x[9:5]} instead of SRAM data. The SRAM is still
//   read and the latency is unchanged.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   req_strobe          one request slot, every strobe gets one response
//   req_active          fetch wanted (low = answer with skip)
//   req_x, req_y        signed PRECISION+1 bit foreground coordinate
//   fg_pixel_out        returned pixel (holds between responses)
//   fg_pixel_skip       response carries no valid pixel
//   fg_pixel_ready      response valid this cycle
//   sram_addr/rd/we     SRAM word address and strobes (never rd and we at once)
//   sram_wdata          SRAM write data
//   sram_rdata          SRAM read data, valid SRAM_READ_LATENCY cycles after
//                       the address is sampled
//   wr_valid/wr_ready   frame-writer handshake
//   wr_addr/wr_data     frame-writer address and data
// ============================================================================
module fg_fetch_responder #(
    parameter int PIXEL_SIZE        = 16,
    parameter int PRECISION         = 11,
    parameter int RESOLUTION_X      = 800,
    parameter int RESOLUTION_Y      = 600,
    parameter int ADDR_WIDTH        = 19,
    parameter int SRAM_READ_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef FG_RESPONDER_TEST_PATTERN_EN
    input  logic                         ctrl_test_pattern,
`endif
    input  logic                         req_strobe,
    input  logic                         req_active,
    input  logic signed [PRECISION:0]    req_x,
    input  logic signed [PRECISION:0]    req_y,
    output logic [PIXEL_SIZE-1:0]        fg_pixel_out,
    output logic                         fg_pixel_skip,
    output logic                         fg_pixel_ready,
    output logic [ADDR_WIDTH-1:0]        sram_addr,
    output logic                         sram_rd,
    output logic                         sram_we,
    output logic [PIXEL_SIZE-1:0]        sram_wdata,
    input  logic [PIXEL_SIZE-1:0]        sram_rdata,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [PIXEL_SIZE-1:0]        wr_data
);

    // Slot k is loaded at the capture edge E0 and reaches index k at edge Ek.
    // The last index is the registered response flag itself.
    localparam int RLAT  = SRAM_READ_LATENCY;
    localparam int DEPTH = SRAM_READ_LATENCY + 2;

    logic [DEPTH-1:0]       slot_vld;
    logic [DEPTH-1:0]       slot_skip;

    logic                   hold_vld;
    logic [ADDR_WIDTH-1:0]  hold_addr;
    logic [PIXEL_SIZE-1:0]  hold_data;

    logic [31:0]            x_ext;
    logic [31:0]            y_ext;
    logic [31:0]            addr_full;
    logic                   x_ok;
    logic                   y_ok;
    logic                   rd_issue;
    logic                   skip_issue;
    logic                   drain;
    logic [PIXEL_SIZE-1:0]  resp_rd_data;

    // Request decode. The sign bit is checked first, so the zero-extended
    // magnitude compare is only trusted for non-negative coordinates.
    always_comb begin
        x_ext      = 32'($unsigned(req_x));
        y_ext      = 32'($unsigned(req_y));
        x_ok       = !req_x[PRECISION] && (x_ext < 32'(RESOLUTION_X));
        y_ok       = !req_y[PRECISION] && (y_ext < 32'(RESOLUTION_Y));
        rd_issue   = req_strobe && req_active && x_ok && y_ok;
        skip_issue = req_strobe && !rd_issue;
        addr_full  = y_ext * 32'(RESOLUTION_X) + x_ext;
        // A read always wins the SRAM port; the pending write waits.
        drain      = hold_vld && !rd_issue;
    end

`ifdef FG_RESPONDER_TEST_PATTERN_EN
    // The pattern travels with the request so that it lines up with the SRAM
    // data of the same slot. It is pure data, so it has no reset.
    logic [PIXEL_SIZE-1:0] pat_p [RLAT+1];
    logic [RLAT:0]         tp_p;

    always_ff @(posedge clk) begin
        pat_p[0] <= PIXEL_SIZE'({req_x[4:0], req_y[5:0], req_x[9:5]});
        tp_p[0]  <= ctrl_test_pattern;
        for (int i = 1; i <= RLAT; i++) begin
            pat_p[i] <= pat_p[i-1];
            tp_p[i]  <= tp_p[i-1];
        end
    end

    assign resp_rd_data = tp_p[RLAT] ? pat_p[RLAT] : sram_rdata;
`else
    assign resp_rd_data = sram_rdata;
`endif

    // ---- capture edge E0 through response edge E(RLAT+1) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld     <= '0;
            slot_skip    <= '0;
            fg_pixel_out <= '0;
            sram_rd      <= 1'b0;
            sram_we      <= 1'b0;
            sram_addr    <= '0;
            sram_wdata   <= '0;
            hold_vld     <= 1'b0;
            hold_addr    <= '0;
            hold_data    <= '0;
        end else begin
            slot_vld  <= {slot_vld[DEPTH-2:0], req_strobe};
            slot_skip <= {slot_skip[DEPTH-2:0], skip_issue};

            // Index DEPTH-2 is the slot whose SRAM data is valid at this edge.
            if (slot_vld[DEPTH-2]) begin
                fg_pixel_out <= slot_skip[DEPTH-2] ? '0 : resp_rd_data;
            end

            sram_rd <= rd_issue;
            sram_we <= drain;
            if (rd_issue) begin
                sram_addr <= addr_full[ADDR_WIDTH-1:0];
            end else if (drain) begin
                sram_addr  <= hold_addr;
                sram_wdata <= hold_data;
            end

            // wr_ready is low while the holding register is full. This
            // rules out a refill on the drain edge itself.
            if (drain) begin
                hold_vld <= 1'b0;
            end else if (wr_valid && !hold_vld) begin
                hold_vld  <= 1'b1;
                hold_addr <= wr_addr;
                hold_data <= wr_data;
            end
        end
    end

    assign fg_pixel_ready = slot_vld[DEPTH-1];
    assign fg_pixel_skip  = slot_skip[DEPTH-1];
    assign wr_ready       = !hold_vld;

endmodule

// File: tb/tb_fg_fetch_responder.sv
module tb_fg_fetch_responder;

    logic               clk = 1'b0;
    logic               rst;
`ifdef FG_RESPONDER_TEST_PATTERN_EN
    logic               ctrl_test_pattern;
`endif
    logic               req_strobe;
    logic               req_active;
    logic signed [11:0] req_x;
    logic signed [11:0] req_y;
    logic [15:0]        fg_pixel_out;
    logic               fg_pixel_skip;
    logic               fg_pixel_ready;
    logic [18:0]        sram_addr;
    logic               sram_rd;
    logic               sram_we;
    logic [15:0]        sram_wdata;
    logic [15:0]        sram_rdata = '0;
    logic               wr_valid;
    logic               wr_ready;
    logic [18:0]        wr_addr;
    logic [15:0]        wr_data;

    logic               force_en;
    logic [15:0]        force_val;

    int n_assert = 0;
    int n_fail   = 0;

    fg_fetch_responder dut (
        .clk            (clk),
        .rst            (rst),
`ifdef FG_RESPONDER_TEST_PATTERN_EN
        .ctrl_test_pattern (ctrl_test_pattern),
`endif
        .req_strobe     (req_strobe),
        .req_active     (req_active),
        .req_x          (req_x),
        .req_y          (req_y),
        .fg_pixel_out   (fg_pixel_out),
        .fg_pixel_skip  (fg_pixel_skip),
        .fg_pixel_ready (fg_pixel_ready),
        .sram_addr      (sram_addr),
        .sram_rd        (sram_rd),
        .sram_we        (sram_we),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data)
    );

    always #5 clk = ~clk;

    // SRAM with one cycle of read latency; contents are address ^ A5A5
    // unless a fixed value is forced.
    always @(posedge clk) begin
        if (sram_rd) sram_rdata <= force_en ? force_val : (sram_addr[15:0] ^ 16'hA5A5);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_strobe = 1'b0;
        req_active = 1'b0;
        req_x      = '0;
        req_y      = '0;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        force_en   = 1'b0;
        force_val  = '0;
`ifdef FG_RESPONDER_TEST_PATTERN_EN
        ctrl_test_pattern = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(fg_pixel_ready), 32'd0);
        check("rst_skip",  32'(fg_pixel_skip),  32'd0);
        check("rst_out",   32'(fg_pixel_out),   32'd0);
        check("rst_rd",    32'(sram_rd),        32'd0);
        check("rst_we",    32'(sram_we),        32'd0);
        check("rst_addr",  32'(sram_addr),      32'd0);
        check("rst_wdata", 32'(sram_wdata),     32'd0);
        check("rst_wrrdy", 32'(wr_ready),       32'd1);
        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(fg_pixel_ready), 32'd0);
        check("post_rst_wrrdy", 32'(wr_ready),       32'd1);

        // Single read x=10 y=2 -> address 1610, data ABCD three cycles later.
        force_en = 1'b1; force_val = 16'hABCD;
        req_strobe = 1'b1; req_active = 1'b1; req_x = 12'sd10; req_y = 12'sd2;
        step();
        req_strobe = 1'b0;
        check("rd1_rd",    32'(sram_rd),        32'd1);
        check("rd1_addr",  32'(sram_addr),      32'd1610);
        check("rd1_we",    32'(sram_we),        32'd0);
        check("rd1_rdy0",  32'(fg_pixel_ready), 32'd0);
        step();
        check("rd1_rd_off", 32'(sram_rd),        32'd0);
        check("rd1_rdy1",   32'(fg_pixel_ready), 32'd0);
        step();
        check("rd1_ready", 32'(fg_pixel_ready), 32'd1);
        check("rd1_skip",  32'(fg_pixel_skip),  32'd0);
        check("rd1_out",   32'(fg_pixel_out),   32'hABCD);
        step();
        check("rd1_ready_off", 32'(fg_pixel_ready), 32'd0);
        check("rd1_out_hold",  32'(fg_pixel_out),   32'hABCD);
        force_en = 1'b0;

        // Out-of-frame x=-1 then x=800: two skips, no SRAM read.
        req_strobe = 1'b1; req_active = 1'b1; req_x = -12'sd1; req_y = 12'sd0;
        step();
        check("oob_rd_a", 32'(sram_rd), 32'd0);
        req_x = 12'sd800;
        step();
        check("oob_rd_b", 32'(sram_rd), 32'd0);
        req_strobe = 1'b0;
        step();
        check("oob1_ready", 32'(fg_pixel_ready), 32'd1);
        check("oob1_skip",  32'(fg_pixel_skip),  32'd1);
        check("oob1_out",   32'(fg_pixel_out),   32'd0);
        step();
        check("oob2_ready", 32'(fg_pixel_ready), 32'd1);
        check("oob2_skip",  32'(fg_pixel_skip),  32'd1);
        check("oob2_out",   32'(fg_pixel_out),   32'd0);
        step();
        check("oob_ready_off", 32'(fg_pixel_ready), 32'd0);

        // Inactive in-frame request, then y=600 (just outside): both skip.
        req_strobe = 1'b1; req_active = 1'b0; req_x = 12'sd5; req_y = 12'sd0;
        step();
        check("inact_rd", 32'(sram_rd), 32'd0);
        req_active = 1'b1; req_y = 12'sd600;
        step();
        check("ymax_rd", 32'(sram_rd), 32'd0);
        req_strobe = 1'b0;
        step();
        check("inact_ready", 32'(fg_pixel_ready), 32'd1);
        check("inact_skip",  32'(fg_pixel_skip),  32'd1);
        step();
        check("ymax_ready", 32'(fg_pixel_ready), 32'd1);
        check("ymax_skip",  32'(fg_pixel_skip),  32'd1);
        step();
        check("skip_ready_off", 32'(fg_pixel_ready), 32'd0);
        check("skip_skip_off",  32'(fg_pixel_skip),  32'd0);

        // 800 back-to-back reads on row 1, with a write offered at slot 10.
        for (int i = 0; i < 803; i++) begin
            if (i < 800) begin
                req_strobe = 1'b1; req_active = 1'b1;
                req_x = 12'(i); req_y = 12'sd1;
            end else begin
                req_strobe = 1'b0;
            end
            wr_valid = (i == 10);
            wr_addr  = 19'd5;
            wr_data  = 16'h1234;
            step();
            if (i < 800) begin
                check("burst_rd",   32'(sram_rd),   32'd1);
                check("burst_addr", 32'(sram_addr), 32'(800 + i));
            end
            check("burst_we",    32'(sram_we),  (i == 800) ? 32'd1 : 32'd0);
            check("burst_wrrdy", 32'(wr_ready), (i >= 10 && i < 800) ? 32'd0 : 32'd1);
            if (i == 800) begin
                check("drain_rd",    32'(sram_rd),    32'd0);
                check("drain_addr",  32'(sram_addr),  32'd5);
                check("drain_wdata", 32'(sram_wdata), 32'h1234);
            end
            check("burst_ready", 32'(fg_pixel_ready), (i >= 2 && i <= 801) ? 32'd1 : 32'd0);
            if (i >= 2 && i <= 801) begin
                check("burst_skip", 32'(fg_pixel_skip), 32'd0);
                check("burst_out",  32'(fg_pixel_out),  32'(16'(800 + i - 2) ^ 16'hA5A5));
            end
        end
        wr_valid = 1'b0;

`ifdef FG_RESPONDER_TEST_PATTERN_EN
        // Pattern for x=33 y=7: {00001, 000111, 00001} = 16'h08E1.
        ctrl_test_pattern = 1'b1;
        req_strobe = 1'b1; req_active = 1'b1; req_x = 12'sd33; req_y = 12'sd7;
        step();
        req_strobe = 1'b0;
        check("tp_rd",   32'(sram_rd),   32'd1);
        check("tp_addr", 32'(sram_addr), 32'd5633);
        step();
        step();
        check("tp_ready", 32'(fg_pixel_ready), 32'd1);
        check("tp_skip",  32'(fg_pixel_skip),  32'd0);
        check("tp_out",   32'(fg_pixel_out),   32'h08E1);
        ctrl_test_pattern = 1'b0;
        step();
`endif

        // Reset with two reads in flight and a pending write.
        req_strobe = 1'b1; req_active = 1'b1; req_x = 12'sd3; req_y = 12'sd0;
        wr_valid = 1'b1; wr_addr = 19'd9; wr_data = 16'h0077;
        step();
        req_x = 12'sd4;
        wr_valid = 1'b0;
        step();
        check("pre_rst_wrrdy", 32'(wr_ready), 32'd0);
        check("pre_rst_rd",    32'(sram_rd),  32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", 32'(fg_pixel_ready), 32'd0);
        check("arst_skip",  32'(fg_pixel_skip),  32'd0);
        check("arst_out",   32'(fg_pixel_out),   32'd0);
        check("arst_rd",    32'(sram_rd),        32'd0);
        check("arst_we",    32'(sram_we),        32'd0);
        check("arst_addr",  32'(sram_addr),      32'd0);
        check("arst_wdata", 32'(sram_wdata),     32'd0);
        check("arst_wrrdy", 32'(wr_ready),       32'd1);
        req_strobe = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("after_rst_ready", 32'(fg_pixel_ready), 32'd0);
            check("after_rst_we",    32'(sram_we),        32'd0);
            check("after_rst_wrrdy", 32'(wr_ready),       32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
